hub75_bitplane_fetch: RTL and testbench

- Upstream pixel source for the HUB75 scan/shift driver. It replaces the constant-white colour inputs.
- For each (scan row, bitplane) request from the driver, it reads one row pair from the framebuffer RAM and streams WIDTH column words of {R1,G1,B1,R2,G2,B2} bits. These are the bits of the selected binary-coded-modulation plane.
- Sits between the framebuffer's read port and the driver's column shifter.

---
 rtl/hub75_pkg.sv | 29 ++
 rtl/hub75_skid_fifo.sv | 59 +++++
 rtl/hub75_bitplane_fetch.sv | 141 ++++++++++++++
 tb/tb_hub75_bitplane_fetch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 pixel path: FSM states, framebuffer
// channel indices and the pix_rgb bit order agreed with the scan driver.
package hub75_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int NUM_CH   = 6;
    localparam int CH_R_TOP = 0;
    localparam int CH_G_TOP = 1;
    localparam int CH_B_TOP = 2;
    localparam int CH_R_BOT = 3;
    localparam int CH_G_BOT = 4;
    localparam int CH_B_BOT = 5;

    localparam int PIX_R1 = 0;
    localparam int PIX_G1 = 1;
    localparam int PIX_B1 = 2;
    localparam int PIX_R2 = 3;
    localparam int PIX_G2 = 4;
    localparam int PIX_B2 = 5;

    // FIFO word: {last, rgb[5:0]}
    localparam int FIFO_W = NUM_CH + 1;

endpackage

// File: rtl/hub75_skid_fifo.sv
// Two-entry skid FIFO for {last, rgb}; an arriving word is passed straight
// through when the FIFO is empty so a steady stream has no added latency.
module hub75_skid_fifo
    import hub75_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [FIFO_W-1:0] in_data,
    output logic              out_valid,
    output logic [FIFO_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        count
);

    logic [1:0][FIFO_W-1:0] mem_q, mem_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic [1:0]             count_q, count_d;
    logic                   empty, bypass, wr_en, rd_en;

    always_comb begin
        empty     = (count_q == 2'd0);
        out_valid = !empty || in_valid;
        out_data  = '0;
        if (!empty) begin
            out_data = mem_q[rd_ptr_q];
        end else if (in_valid) begin
            out_data = in_data;
        end
        bypass   = empty && in_valid && out_ready;
        wr_en    = in_valid && !bypass;
        rd_en    = !empty && out_ready;
        count_d  = count_q + {1'b0, wr_en} - {1'b0, rd_en};
        rd_ptr_d = rd_ptr_q ^ rd_en;
        wr_ptr_d = wr_ptr_q ^ wr_en;
        mem_d    = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hub75_bitplane_fetch.sv
// Fetches one framebuffer row pair per (row, plane) request and streams the
// selected bitplane as WIDTH six-bit column words to the HUB75 shifter.
module hub75_bitplane_fetch
    import hub75_pkg::*;
#(
    parameter  int WIDTH      = 64,
    parameter  int ROWS       = 32,
    parameter  int COLOR_BITS = 4,
    localparam int ROW_W      = $clog2(ROWS),
    localparam int COL_W      = $clog2(WIDTH),
    localparam int PLANE_W    = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1,
    localparam int ADDR_W     = ROW_W + COL_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ROW_W-1:0]             req_row,
    input  logic [PLANE_W-1:0]           req_plane,
    output logic                         mem_rd,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [NUM_CH*COLOR_BITS-1:0] mem_rdata,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic [NUM_CH-1:0]            pix_rgb,
    output logic                         pix_last
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [PLANE_W-1:0] plane_q, plane_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               req_ready_q, req_ready_d;
    logic               inflight_q, inflight_d;
    logic               last_inflight_q, last_inflight_d;
    logic [1:0]         fifo_count;
    logic [FIFO_W-1:0]  fifo_in, fifo_out;
    logic               pop, credit_ok;

    // Planes at or beyond COLOR_BITS select nothing and yield all-zero words.
    function automatic logic [NUM_CH-1:0] select_bits(
        input logic [NUM_CH*COLOR_BITS-1:0] word,
        input logic [PLANE_W-1:0]           plane
    );
        logic [NUM_CH-1:0] bits;
        bits = '0;
        for (int b = 0; b < COLOR_BITS; b++) begin
            if (int'(plane) == b) begin
                bits[PIX_R1] = word[CH_R_TOP*COLOR_BITS + b];
                bits[PIX_G1] = word[CH_G_TOP*COLOR_BITS + b];
                bits[PIX_B1] = word[CH_B_TOP*COLOR_BITS + b];
                bits[PIX_R2] = word[CH_R_BOT*COLOR_BITS + b];
                bits[PIX_G2] = word[CH_G_BOT*COLOR_BITS + b];
                bits[PIX_B2] = word[CH_B_BOT*COLOR_BITS + b];
            end
        end
        return bits;
    endfunction

    // A read may issue only if its data still fits after this cycle's pop.
    always_comb begin
        pop       = pix_valid && pix_ready;
        credit_ok = ({1'b0, fifo_count} + {2'b0, inflight_q} + 3'd1) <= (3'd2 + {2'b0, pop});
        mem_rd    = (state_q == FETCH) && credit_ok;
        mem_addr  = {row_q, col_q};
        fifo_in   = {last_inflight_q, select_bits(mem_rdata, plane_q)};

        inflight_d      = mem_rd;
        last_inflight_d = mem_rd && (col_q == COL_LAST);
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        plane_d = plane_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    row_d   = req_row;
                    plane_d = req_plane;
                    col_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (mem_rd) begin
                    col_d = col_q + COL_W'(1);
                    if (col_q == COL_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && pix_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            row_q           <= '0;
            plane_q         <= '0;
            col_q           <= '0;
            req_ready_q     <= 1'b0;
            inflight_q      <= 1'b0;
            last_inflight_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            plane_q         <= plane_d;
            col_q           <= col_d;
            req_ready_q     <= req_ready_d;
            inflight_q      <= inflight_d;
            last_inflight_q <= last_inflight_d;
        end
    end

    hub75_skid_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inflight_q),
        .in_data   (fifo_in),
        .out_valid (pix_valid),
        .out_data  (fifo_out),
        .out_ready (pix_ready),
        .count     (fifo_count)
    );

    assign req_ready = req_ready_q;
    assign pix_rgb   = fifo_out[NUM_CH-1:0];
    assign pix_last  = fifo_out[NUM_CH];

endmodule

// File: tb/tb_hub75_bitplane_fetch.sv
// Bench for hub75_bitplane_fetch: table-driven rows with a scoreboard, plus
// hand sequences for busy requests, mid-row reset and COLOR_BITS=3.
module tb_hub75_bitplane_fetch;

    localparam int W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, mem_rd, pix_valid, pix_ready, pix_last;
    logic [4:0]  req_row;
    logic [1:0]  req_plane;
    logic [10:0] mem_addr;
    logic [23:0] mem_rdata;
    logic [5:0]  pix_rgb;

    logic        req_valid3, req_ready3, mem_rd3, pix_valid3, pix_ready3, pix_last3;
    logic [4:0]  req_row3;
    logic [1:0]  req_plane3;
    logic [10:0] mem_addr3;
    logic [17:0] mem_rdata3;
    logic [5:0]  pix_rgb3;

    hub75_bitplane_fetch #(.WIDTH(64), .ROWS(32), .COLOR_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_plane(req_plane), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_rgb(pix_rgb), .pix_last(pix_last)
    );

    hub75_bitplane_fetch #(.WIDTH(64), .ROWS(32), .COLOR_BITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_row(req_row3), .req_plane(req_plane3), .mem_rd(mem_rd3), .mem_addr(mem_addr3),
        .mem_rdata(mem_rdata3), .pix_valid(pix_valid3), .pix_ready(pix_ready3),
        .pix_rgb(pix_rgb3), .pix_last(pix_last3)
    );

    logic [23:0] ram [0:2047];

    function automatic logic [17:0] ram3_word(input logic [10:0] a);
        logic [17:0] w;
        logic [2:0]  v;
        w = '0;
        for (int ch = 0; ch < 6; ch++) begin
            v = a[2:0] + 3'(ch);
            w = w | (18'(v) << (ch * 3));
        end
        return w;
    endfunction

    always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];
    always @(posedge clk) if (mem_rd3) mem_rdata3 <= ram3_word(mem_addr3);

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [5:0] exp_bits(input logic [23:0] w, input int pl);
        logic [5:0]  r;
        logic [23:0] s;
        for (int ch = 0; ch < 6; ch++) begin
            s = w >> (ch * 4 + pl);
            r[ch] = s[0];
        end
        return r;
    endfunction

    logic [6:0]  exp_q[$];
    logic [10:0] addr_q[$];
    int          rd_cnt = 0;
    int          wd_cnt = 0;
    int          last_cyc = -10;
    int          acc_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [6:0]  prev_word = '0;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(pix_valid), 32'd1);
                chk("stall_word", 32'({pix_last, pix_rgb}), 32'(prev_word));
            end
            if (mem_rd) begin
                if (addr_q.size() == 0) fail("unexpected_read");
                else chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
                chk("credit", 32'((rd_cnt - wd_cnt + 1 - ((pix_valid && pix_ready) ? 1 : 0)) <= 2), 32'd1);
            end
            if (rd_cnt != wd_cnt) chk("occupancy", 32'((rd_cnt - wd_cnt) <= 2), 32'd1);
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) fail("unexpected_word");
                else chk("pix_word", 32'({pix_last, pix_rgb}), 32'(exp_q.pop_front()));
                if (pix_last) last_cyc = cyc;
            end
            if (cyc == last_cyc) chk("req_ready_at_last", 32'(req_ready), 32'd0);
            if (cyc == last_cyc + 1) chk("req_ready_after_last", 32'(req_ready), 32'd1);
            if (mem_rd) rd_cnt++;
            if (pix_valid && pix_ready) wd_cnt++;
            prev_stall = pix_valid && !pix_ready;
            prev_word  = {pix_last, pix_rgb};
        end
    end

    task automatic fill(input int mode);
        for (int a = 0; a < 2048; a++) begin
            case (mode)
                0:       ram[a] = 24'(a & 15);
                1:       ram[a] = 24'h800000;
                default: ram[a] = 24'($urandom);
            endcase
        end
    endtask

    task automatic start_req(input int row, input int plane);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) fail("req_ready_timeout");
        for (int c = 0; c < W; c++) begin
            addr_q.push_back(11'(row * W + c));
            exp_q.push_back({c == W - 1, exp_bits(ram[row * W + c], plane)});
        end
        acc_cyc   = cyc;
        req_valid = 1'b1;
        req_row   = 5'(row);
        req_plane = 2'(plane);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_row   = 5'($urandom);
        req_plane = 2'($urandom);
    endtask

    task automatic wait_done(input bit rnd);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            pix_ready = rnd ? 1'($urandom % 2) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
        pix_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (!rnd) chk("row_latency", 32'(last_cyc), 32'(acc_cyc + W + 1));
        chk("addr_queue_empty", 32'(addr_q.size()), 32'd0);
    endtask

    typedef struct {
        int row;
        int plane;
        int fill_mode;
        bit rnd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base, n, k;
        logic [5:0] e;
        logic [2:0] v;

        vecs[0] = '{row: 3,  plane: 1, fill_mode: 0, rnd: 1'b0};
        vecs[1] = '{row: 31, plane: 3, fill_mode: 1, rnd: 1'b0};
        vecs[2] = '{row: 3,  plane: 1, fill_mode: 0, rnd: 1'b1};
        vecs[3] = '{row: 12, plane: 2, fill_mode: 2, rnd: 1'b0};
        vecs[4] = '{row: 0,  plane: 0, fill_mode: 2, rnd: 1'b1};
        vecs[5] = '{row: 20, plane: 3, fill_mode: 2, rnd: 1'b1};

        req_valid = 0; req_row = 0; req_plane = 0; pix_ready = 0;
        req_valid3 = 0; req_row3 = 0; req_plane3 = 0; pix_ready3 = 1;
        mem_rdata = '0; mem_rdata3 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            fill(vecs[i].fill_mode);
            start_req(vecs[i].row, vecs[i].plane);
            wait_done(vecs[i].rnd);
        end

        // Request while busy is ignored; row 5 is taken only once idle again.
        fill(0);
        pix_ready = 1'b1;
        start_req(3, 1);
        repeat (3) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_row = 5'd5; req_plane = 2'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done(1'b0);
        start_req(5, 2);
        wait_done(1'b1);

        // Reset in the middle of a row.
        fill(2);
        pix_ready = 1'b1;
        base = wd_cnt;
        start_req(7, 0);
        n = 0;
        while (wd_cnt < base + 10 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (wd_cnt < base + 10) fail("midrow_timeout");
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_mem_rd", 32'(mem_rd), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        chk("midrst_pix_valid", 32'(pix_valid), 32'd0);
        chk("midrst_pix_rgb", 32'(pix_rgb), 32'd0);
        chk("midrst_pix_last", 32'(pix_last), 32'd0);
        exp_q.delete();
        addr_q.delete();
        rd_cnt = 0;
        wd_cnt = 0;
        last_cyc = -10;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_release_ready", 32'(req_ready), 32'd1);
        repeat (5) begin
            chk("post_rst_no_valid", 32'(pix_valid), 32'd0);
            chk("post_rst_no_read", 32'(mem_rd), 32'd0);
            @(posedge clk); #1;
        end
        start_req(9, 1);
        wait_done(1'b0);

        // COLOR_BITS=3 instance: out-of-range plane, then the MSB plane.
        for (int pl = 3; pl >= 2; pl--) begin
            n = 0;
            while (!req_ready3 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (!req_ready3) fail("cb3_req_timeout");
            req_valid3 = 1'b1;
            req_row3   = 5'd4;
            req_plane3 = 2'(pl);
            @(posedge clk); #1;
            req_valid3 = 1'b0;
            k = 0;
            n = 0;
            while (k < W && n < 500) begin
                @(negedge clk);
                n++;
                if (pix_valid3) begin
                    e = '0;
                    if (pl == 2) begin
                        for (int ch = 0; ch < 6; ch++) begin
                            v = 3'(k + ch);
                            e[ch] = v[2];
                        end
                    end
                    chk("cb3_word", 32'({pix_last3, pix_rgb3}), 32'({k == W - 1, e}));
                    k++;
                end
            end
            if (k < W) fail("cb3_timeout");
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
